noc_tx_packetizer: RTL and testbench

- Injection-side network interface between a TPC's local SRAM and the local input port of its mesh router.
- Accepts one transfer command at a time: destination router, source SRAM address, destination address, beat count.
- Emits one header flit, then LEN payload flits read from SRAM, all carrying the command's dest_x/dest_y.
- Valid/ready output, one flit/cycle sustained, holds flits under backpressure.

---
 rtl/noc_tx_packetizer.sv | 159 +++++++++++++++
 tb/tb_noc_tx_packetizer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_tx_packetizer.sv
// noc_tx_packetizer: injection-side NoC interface. Reads LEN words from local SRAM
// and sends them as one header flit plus LEN payload flits to the mesh router.
`default_nettype none

module noc_tx_packetizer #(
   parameter int DATA_WIDTH = 256,
   parameter int ADDR_WIDTH = 20,
   parameter int COORD_BITS = 4,
   parameter int LEN_BITS   = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [COORD_BITS-1:0] cmd_dest_x,
   input  logic [COORD_BITS-1:0] cmd_dest_y,
   input  logic [ADDR_WIDTH-1:0] cmd_src_addr,
   input  logic [ADDR_WIDTH-1:0] cmd_dst_addr,
   input  logic [LEN_BITS-1:0]   cmd_len,
   output logic                  sram_rd_en,
   output logic [ADDR_WIDTH-1:0] sram_rd_addr,
   input  logic [DATA_WIDTH-1:0] sram_rd_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [COORD_BITS-1:0] out_dest_x,
   output logic [COORD_BITS-1:0] out_dest_y,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
);

   localparam int HDR_PAD = DATA_WIDTH - 1 - ADDR_WIDTH - LEN_BITS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]            state;
   logic [COORD_BITS-1:0] dest_x;
   logic [COORD_BITS-1:0] dest_y;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [ADDR_WIDTH-1:0] dst_addr;
   logic [LEN_BITS-1:0]   len;
   logic [LEN_BITS-1:0]   rd_cnt;
   logic [LEN_BITS-1:0]   tx_cnt;
   logic                  rd_pend;
   logic [DATA_WIDTH-1:0] fifo_mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            fifo_cnt;

   logic                  in_xfer;
   logic [1:0]            occupancy;
   logic                  rd_issue;
   logic                  pay_valid;
   logic                  fire;
   logic                  pay_pop;
   logic                  fifo_pop;
   logic                  bypass;
   logic                  fifo_push;
   logic                  last_pay;
   logic [DATA_WIDTH-1:0] header;

   assign in_xfer   = (state == S_HDR) || (state == S_DATA);
   // Data returning this cycle counts toward occupancy so the FIFO can never overflow.
   assign occupancy = fifo_cnt + {1'b0, rd_pend};
   assign rd_issue  = in_xfer && (rd_cnt != len) && (occupancy < 2'd2);
   assign pay_valid = (state == S_DATA) && ((fifo_cnt != 2'd0) || rd_pend);
   assign out_valid = (state == S_HDR) || pay_valid;
   assign fire      = out_valid && out_ready;
   assign pay_pop   = (state == S_DATA) && fire;
   assign fifo_pop  = pay_pop && (fifo_cnt != 2'd0);
   assign bypass    = pay_pop && (fifo_cnt == 2'd0);
   assign fifo_push = rd_pend && !bypass;
   assign last_pay  = (tx_cnt == len - LEN_BITS'(1));
   assign header    = {1'b1, {HDR_PAD{1'b0}}, len, dst_addr};

   assign cmd_ready    = (state == S_IDLE);
   assign busy         = (state != S_IDLE);
   assign done         = (state == S_DONE);
   assign sram_rd_en   = rd_issue;
   assign sram_rd_addr = src_addr + ADDR_WIDTH'(rd_cnt);
   assign out_dest_x   = out_valid ? dest_x : '0;
   assign out_dest_y   = out_valid ? dest_y : '0;

   always_comb begin
      out_data = '0;
      if (state == S_HDR)
         out_data = header;
      else if (pay_valid)
         out_data = (fifo_cnt != 2'd0) ? fifo_mem[rd_ptr] : sram_rd_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         dest_x   <= '0;
         dest_y   <= '0;
         src_addr <= '0;
         dst_addr <= '0;
         len      <= '0;
         rd_cnt   <= '0;
         tx_cnt   <= '0;
         rd_pend  <= 1'b0;
      end else begin
         rd_pend <= rd_issue;
         if (rd_issue)
            rd_cnt <= rd_cnt + LEN_BITS'(1);
         if (pay_pop)
            tx_cnt <= tx_cnt + LEN_BITS'(1);
         case (state)
            S_IDLE: begin
               if (cmd_valid) begin
                  dest_x   <= cmd_dest_x;
                  dest_y   <= cmd_dest_y;
                  src_addr <= cmd_src_addr;
                  dst_addr <= cmd_dst_addr;
                  len      <= cmd_len;
                  rd_cnt   <= '0;
                  tx_cnt   <= '0;
                  state    <= S_HDR;
               end
            end
            S_HDR: begin
               if (fire)
                  state <= (len == '0) ? S_DONE : S_DATA;
            end
            S_DATA: begin
               if (pay_pop && last_pay)
                  state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         fifo_cnt <= 2'd0;
      end else begin
         if (fifo_push)
            wr_ptr <= ~wr_ptr;
         if (fifo_pop)
            rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, fifo_push} - {1'b0, fifo_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (fifo_push)
         fifo_mem[wr_ptr] <= sram_rd_data;
   end

endmodule

`default_nettype wire

// File: tb/tb_noc_tx_packetizer.sv
// tb_noc_tx_packetizer: randomized self-checking bench with a flit-queue reference model.
`default_nettype none

module tb_noc_tx_packetizer;

   localparam int DW = 256;
   localparam int AW = 20;
   localparam int CB = 4;
   localparam int LB = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [CB-1:0] cmd_dest_x, cmd_dest_y;
   logic [AW-1:0] cmd_src_addr, cmd_dst_addr;
   logic [LB-1:0] cmd_len;
   logic          sram_rd_en;
   logic [AW-1:0] sram_rd_addr;
   logic [DW-1:0] sram_rd_data;
   logic [DW-1:0] out_data;
   logic [CB-1:0] out_dest_x, out_dest_y;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;

   int n_checks = 0;
   int n_errors = 0;

   noc_tx_packetizer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COORD_BITS(CB), .LEN_BITS(LB)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_dest_x(cmd_dest_x), .cmd_dest_y(cmd_dest_y),
      .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_len(cmd_len),
      .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
      .out_data(out_data), .out_dest_x(out_dest_x), .out_dest_y(out_dest_y),
      .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] sram_word(input logic [AW-1:0] a);
      logic [DW-1:0] w;
      for (int i = 0; i < DW / 32; i++)
         w[i*32 +: 32] = (32'(a) * 32'h9E3779B1) + (32'(i) * 32'h01234567) + 32'd1;
      return w;
   endfunction

   // SRAM: one-cycle read latency, junk on cycles without a read
   always @(posedge clk)
      sram_rd_data <= sram_rd_en ? sram_word(sram_rd_addr) : {8{$urandom}};

   // ---------------- reference model / scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   int            cyc = 0, acc_cyc = 0, last_done_cyc = 0;
   int            m_len, rd_issued, pay_out, flit_idx;
   bit            m_active, m_done_due, m_timed, timed_mode, prev_stall;
   logic [DW-1:0] prev_data;
   logic [CB-1:0] m_dx, m_dy, prev_dx, prev_dy;
   logic [AW-1:0] exp_addr;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         m_active = 0; m_done_due = 0; prev_stall = 0;
      end else begin
         cyc++;
         chk("busy", busy, m_active);
         chk("cmd_ready", cmd_ready, !m_active);
         chk("done", done, m_done_due);
         if (!out_valid) begin
            chk("idle_dest", {out_dest_x, out_dest_y}, '0);
         end
         if (m_done_due) begin
            chk("read_count", rd_issued, m_len);
            if (m_timed) chk("done_cycle", cyc - acc_cyc, m_len + 2);
            last_done_cyc = cyc;
            m_active = 0; m_done_due = 0;
         end
         if (sram_rd_en) begin
            chk("rd_during_xfer", m_active, 1);
            chk("rd_addr", sram_rd_addr, exp_addr);
            exp_addr++;
            rd_issued++;
            chk("rd_ahead_le2", (rd_issued - pay_out) <= 2, 1);
            chk("rd_le_len", rd_issued <= m_len, 1);
         end
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_data", out_data, prev_data);
            chk("stall_dest", {out_dest_x, out_dest_y}, {prev_dx, prev_dy});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_flit", 1, 0);
            end else begin
               chk("flit_data", out_data, exp_q[0]);
               chk("flit_dest", {out_dest_x, out_dest_y}, {m_dx, m_dy});
               if (m_timed) chk("flit_cycle", cyc - acc_cyc, flit_idx + 1);
               if (flit_idx > 0) pay_out++;
               flit_idx++;
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) m_done_due = 1;
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_dx    = out_dest_x;
         prev_dy    = out_dest_y;
         if (cmd_valid && cmd_ready) begin
            logic [DW-1:0] h;
            h = '0;
            h[AW-1:0]   = cmd_dst_addr;
            h[AW +: LB] = cmd_len;
            h[DW-1]     = 1'b1;
            exp_q.push_back(h);
            for (int k = 0; k < int'(cmd_len); k++)
               exp_q.push_back(sram_word(cmd_src_addr + AW'(k)));
            m_active = 1; m_len = int'(cmd_len); m_dx = cmd_dest_x; m_dy = cmd_dest_y;
            exp_addr = cmd_src_addr; rd_issued = 0; pay_out = 0; flit_idx = 0;
            acc_cyc = cyc; m_timed = timed_mode;
         end
      end
   end

   // ---------------- driver ----------------
   // mode 0: always ready; 1: toggle 8 cycles, low 5, then high; 2: random
   function automatic logic ready_val(input int mode, input int i);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (i < 8) ? ((i % 2) == 0) : (i >= 13);
      return ($urandom_range(0, 9) < 7);
   endfunction

   task automatic issue(input logic [CB-1:0] dx, input logic [CB-1:0] dy, input logic [AW-1:0] src,
                        input logic [AW-1:0] dst, input logic [LB-1:0] len, input int mode);
      int guard = 0;
      @(posedge clk); #1;
      cmd_valid = 1; cmd_dest_x = dx; cmd_dest_y = dy;
      cmd_src_addr = src; cmd_dst_addr = dst; cmd_len = len;
      out_ready = ready_val(mode, 0);
      @(negedge clk);
      while (!cmd_ready && guard < 500) begin
         @(negedge clk); guard++;
      end
      if (!cmd_ready) chk("accept_timeout", 0, 1);
      @(posedge clk); #1;
      cmd_valid = 0;
      cmd_dest_x = $urandom; cmd_dest_y = $urandom; cmd_len = $urandom;
      out_ready = ready_val(mode, 0);
   endtask

   task automatic wait_done(input int mode);
      int i = 1;
      bit seen = 0;
      while (!seen && i < 2000) begin
         @(negedge clk);
         if (done) seen = 1;
         else begin
            @(posedge clk); #1;
            out_ready = ready_val(mode, i);
            i++;
         end
      end
      if (!seen) chk("done_timeout", 0, 1);
   endtask

   task automatic run(input logic [CB-1:0] dx, input logic [CB-1:0] dy, input logic [AW-1:0] src,
                      input logic [AW-1:0] dst, input logic [LB-1:0] len, input int mode, input bit timed);
      timed_mode = timed;
      issue(dx, dy, src, dst, len, mode);
      wait_done(mode);
   endtask

   initial begin
      rst_n = 0; cmd_valid = 0; out_ready = 0; timed_mode = 0;
      cmd_dest_x = '0; cmd_dest_y = '0; cmd_src_addr = '0; cmd_dst_addr = '0; cmd_len = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rd_en", sram_rd_en, 0);
      chk("rst_busy_done", {busy, done}, 2'b00);
      chk("rst_out_data", out_data, '0);
      @(posedge clk); #1 rst_n = 1;

      // basic, header-only, backpressure, address wrap
      run(4'd2, 4'd1, 20'h00010, 20'h0ABCD, 8'd4, 0, 1);
      run(4'd7, 4'd3, 20'h00100, 20'h12345, 8'd0, 0, 1);
      run(4'd1, 4'd5, 20'h00200, 20'h00042, 8'd8, 1, 0);
      run(4'd0, 4'd0, 20'hFFFFE, 20'h54321, 8'd4, 0, 1);

      // second command offered while busy; taken when cmd_ready returns
      timed_mode = 1;
      issue(4'd3, 4'd3, 20'h00300, 20'h0BEEF, 8'd5, 0);
      @(posedge clk); #1;
      cmd_valid = 1; cmd_dest_x = 4'd9; cmd_dest_y = 4'd8;
      cmd_src_addr = 20'h00777; cmd_dst_addr = 20'h0CAFE; cmd_len = 8'd3;
      wait_done(0);
      issue(4'd9, 4'd8, 20'h00777, 20'h0CAFE, 8'd3, 0);
      chk("busy_accept_cycle", acc_cyc - last_done_cyc, 1);
      wait_done(0);

      // reset after the 2nd payload flit of a len-6 transfer
      issue(4'd6, 4'd2, 20'h00400, 20'h00099, 8'd6, 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 0;
      #1;
      chk("abort_out_valid", out_valid, 0);
      chk("abort_rd_en", sram_rd_en, 0);
      chk("abort_busy_done", {busy, done}, 2'b00);
      chk("abort_cmd_ready", cmd_ready, 1);
      chk("abort_dest", {out_dest_x, out_dest_y}, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("abort_no_done", done, 0);
      @(posedge clk); #1 rst_n = 1;
      run(4'd5, 4'd5, 20'h00500, 20'h00777, 8'd2, 0, 1);

      // randomized transfers under random backpressure
      for (int t = 0; t < 25; t++) begin
         logic [AW-1:0] src;
         logic [LB-1:0] len;
         len = ($urandom_range(0, 3) == 0) ? LB'($urandom_range(0, 2)) : LB'($urandom_range(1, 20));
         src = ($urandom_range(0, 1) == 1) ? (20'hFFFF0 + AW'($urandom_range(0, 15))) : AW'($urandom);
         run(CB'($urandom), CB'($urandom), src, AW'($urandom), len, 2, 0);
      end
      run(4'd4, 4'd4, 20'h01000, 20'h00001, 8'd16, 0, 1);

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
